// File: rtl/port_tx.sv
// Serial packet transmitter for one router input lane: takes an {addr, payload}
// pair over valid/ready and drives the frame_n / valid_n / di triple.
module port_tx #(
  parameter int WIDTH = 32,
  parameter int PAD   = 5,
  parameter int GAP   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_addr,
  input  logic [WIDTH-1:0] in_payload,
  input  logic             hold,
  output logic             frame_n,
  output logic             valid_n,
  output logic             di,
  output logic             busy,
  output logic             done
);

  localparam int MAXC = (WIDTH > PAD) ? ((WIDTH > 4) ? WIDTH : 4)
                                      : ((PAD > 4) ? PAD : 4);
  localparam int CW   = $clog2(MAXC + 1);
  localparam int GW   = $clog2(GAP + 1);

  localparam logic [CW-1:0] ADDR_LAST = CW'(3);
  localparam logic [CW-1:0] PAD_LAST  = CW'((PAD > 0) ? PAD - 1 : 0);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_MET   = GW'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_PAD,
    S_DATA
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, bits_sent;
  logic [GW-1:0]    gap_q, gap_d;
  logic [3:0]       addr_q, addr_d;
  logic [WIDTH-1:0] pay_q, pay_d;
  logic             frame_n_q, frame_n_d;
  logic             valid_n_q, valid_n_d;
  logic             di_q, di_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             emit_bit;

  assign in_ready = (state_q == S_IDLE) && (gap_q == GAP_MET) && !reset;
  assign accept   = in_valid && in_ready;

  // The registers hold the values for the cycle after each edge, so this
  // block decides what the lane shows next, not what it shows now.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    addr_d    = addr_q;
    pay_d     = pay_q;
    frame_n_d = 1'b0;
    valid_n_d = 1'b1;
    di_d      = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    emit_bit  = 1'b0;
    bits_sent = (state_q == S_DATA) ? cnt_q : '0;

    case (state_q)
      S_IDLE: begin
        frame_n_d = 1'b1;
        busy_d    = 1'b0;
        if (gap_q != GAP_MET) gap_d = gap_q + GW'(1);
        if (accept) begin
          state_d   = S_ADDR;
          cnt_d     = '0;
          addr_d    = in_addr >> 1;
          pay_d     = in_payload;
          frame_n_d = 1'b0;
          di_d      = in_addr[0];
          busy_d    = 1'b1;
        end
      end
      S_ADDR: begin
        if (cnt_q != ADDR_LAST) begin
          cnt_d  = cnt_q + CW'(1);
          di_d   = addr_q[0];
          addr_d = addr_q >> 1;
        end else if (PAD > 0) begin
          state_d = S_PAD;
          cnt_d   = '0;
          di_d    = 1'b1;
        end else begin
          emit_bit = 1'b1;
        end
      end
      S_PAD: begin
        if (cnt_q != PAD_LAST) begin
          cnt_d = cnt_q + CW'(1);
          di_d  = 1'b1;
        end else begin
          emit_bit = 1'b1;
        end
      end
      S_DATA: begin
        // done_q marks that the final bit is on the lane right now.
        if (done_q) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          gap_d     = GW'(1);
          frame_n_d = 1'b1;
          busy_d    = 1'b0;
        end else if (!hold) begin
          emit_bit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit_bit) begin
      state_d   = S_DATA;
      valid_n_d = 1'b0;
      di_d      = pay_q[0];
      pay_d     = pay_q >> 1;
      cnt_d     = bits_sent + CW'(1);
      frame_n_d = (bits_sent == BIT_LAST);
      done_d    = (bits_sent == BIT_LAST);
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gap_q     <= GAP_MET;
      frame_n_q <= 1'b1;
      valid_n_q <= 1'b1;
      di_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      frame_n_q <= frame_n_d;
      valid_n_q <= valid_n_d;
      di_q      <= di_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // NOTE: the shift registers carry no reset; they are loaded on accept and never observed before that.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    pay_q  <= pay_d;
  end

  assign frame_n = frame_n_q;
  assign valid_n = valid_n_q;
  assign di      = di_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_port_tx.sv
// Directed bench for port_tx: captures each packet cycle by cycle and compares
// it with a waveform built from the packet contents and the planned bubbles.
module tb_port_tx;

  logic        clock;
  logic        reset;
  logic        hold;

  logic        in_valid1, in_ready1;
  logic [3:0]  in_addr1;
  logic [31:0] in_payload1;
  logic        frame_n1, valid_n1, di1, busy1, done1;

  logic        in_valid2, in_ready2;
  logic [3:0]  in_addr2;
  logic [7:0]  in_payload2;
  logic        frame_n2, valid_n2, di2, busy2, done2;

  port_tx #(.WIDTH(32), .PAD(5), .GAP(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .in_addr    (in_addr1),
    .in_payload (in_payload1),
    .hold       (hold),
    .frame_n    (frame_n1),
    .valid_n    (valid_n1),
    .di         (di1),
    .busy       (busy1),
    .done       (done1)
  );

  port_tx #(.WIDTH(8), .PAD(0), .GAP(1)) dut_small (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .in_addr    (in_addr2),
    .in_payload (in_payload2),
    .hold       (hold),
    .frame_n    (frame_n2),
    .valid_n    (valid_n2),
    .di         (di2),
    .busy       (busy2),
    .done       (done2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Capture mux: sel picks which instance the capture task watches.
  logic sel;
  logic m_f, m_v, m_d, m_done, m_busy, m_rdy;
  assign m_f    = sel ? frame_n2  : frame_n1;
  assign m_v    = sel ? valid_n2  : valid_n1;
  assign m_d    = sel ? di2       : di1;
  assign m_done = sel ? done2     : done1;
  assign m_busy = sel ? busy2     : busy1;
  assign m_rdy  = sel ? in_ready2 : in_ready1;

  // Behavioural router input receiver on the wide instance's lane.
  logic        rx_in;
  int          rx_acnt;
  logic [3:0]  rx_addr, rx_last_addr;
  logic [31:0] rx_pay, rx_last_pay;
  int          rx_pkts = 0;

  always @(posedge clock) begin
    if (reset) begin
      rx_in   <= 1'b0;
      rx_acnt <= 0;
    end else if (!rx_in) begin
      if (!frame_n1) begin
        rx_in   <= 1'b1;
        rx_acnt <= 1;
        rx_addr <= {di1, rx_addr[3:1]};
      end
    end else if (rx_acnt < 4) begin
      rx_addr <= {di1, rx_addr[3:1]};
      rx_acnt <= rx_acnt + 1;
    end else if (!valid_n1) begin
      rx_pay <= {di1, rx_pay[31:1]};
      if (frame_n1) begin
        rx_in        <= 1'b0;
        rx_last_addr <= rx_addr;
        rx_last_pay  <= {di1, rx_pay[31:1]};
        rx_pkts      <= rx_pkts + 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  logic [63:0] cf, cv, cd, cdone;
  logic [63:0] ef, ev, ed, edone;
  int          clen, elen, busy_bad, ready_hi, rx_before;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected lane waveform; bub[i]=1 makes DATA cycle i a bubble.
  task automatic make_exp(input logic [3:0] a, input logic [31:0] p, input int w,
                          input int pad, input logic [63:0] bub);
    int n = 0;
    int k = 0;
    ef = '1; ev = '1; ed = '0; edone = '0;
    for (int i = 0; i < 4; i++) begin
      ef[n] = 1'b0; ed[n] = a[i]; n++;
    end
    for (int i = 0; i < pad; i++) begin
      ef[n] = 1'b0; ed[n] = 1'b1; n++;
    end
    while (k < w && n < 64) begin
      if (bub[n]) begin
        ef[n] = 1'b0;
      end else begin
        ev[n]    = 1'b0;
        ed[n]    = p[k];
        ef[n]    = (k == w - 1);
        edone[n] = (k == w - 1);
        k++;
      end
      n++;
    end
    elen = n;
  endtask

  // Records one packet from the current cycle until the first idle cycle.
  // hold_plan[i]=1 drives hold during cycle i, so cycle i+1 may be a bubble.
  task automatic capture(input logic [63:0] hold_plan);
    cf = '1; cv = '1; cd = '0; cdone = '0;
    clen = 0; busy_bad = 0; ready_hi = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_f && m_v) break;
      cf[i] = m_f; cv[i] = m_v; cd[i] = m_d; cdone[i] = m_done;
      if (!m_busy) busy_bad++;
      if (m_rdy) ready_hi++;
      clen++;
      hold = hold_plan[i];
      @(negedge clock);
    end
    hold = 1'b0;
  endtask

  task automatic check_pkt(input string tag);
    check({tag, " len"},      64'(clen), 64'(elen));
    check({tag, " frame_n"},  cf, ef);
    check({tag, " valid_n"},  cv, ev);
    check({tag, " di"},       cd, ed);
    check({tag, " done"},     cdone, edone);
    check({tag, " busy low"}, 64'(busy_bad), 64'd0);
    check({tag, " ready hi"}, 64'(ready_hi), 64'd0);
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; hold = 1'b0;
    in_valid1 = 1'b0; in_addr1 = '0; in_payload1 = '0;
    in_valid2 = 1'b0; in_addr2 = '0; in_payload2 = '0;
    repeat (2) @(negedge clock);

    // Reset values.
    check("reset outs", 64'({frame_n1, valid_n1, di1, busy1, done1}), 64'(5'b11000));
    check("reset ready", 64'(in_ready1), 64'd0);
    reset = 1'b0;
    #1;
    check("ready after reset", 64'(in_ready1), 64'd1);

    // Basic packet.
    in_addr1 = 4'hA; in_payload1 = 32'hDEADBEEF; in_valid1 = 1'b1;
    @(negedge clock);
    in_valid1 = 1'b0;
    capture(64'd0);
    make_exp(4'hA, 32'hDEADBEEF, 32, 5, 64'd0);
    check_pkt("basic");
    check("basic len hand", 64'(clen), 64'd41);
    check("basic addr bits", 64'(cd[3:0]), 64'h5 ^ 64'hF);
    check("basic pad di", 64'(cd[8:4]), 64'h1F);
    check("basic pad valid_n", 64'(cv[8:0]), 64'h1FF);
    check("basic payload", 64'(cd[40:9]), 64'hDEADBEEF);
    check("basic frame_n", cf[40:0], {1'b1, 40'd0});
    check("basic done", cdone, 64'h0000_0100_0000_0000);
    check("basic idle outs", 64'({frame_n1, valid_n1, di1, busy1, done1}), 64'(5'b11000));
    check("basic idle ready", 64'(in_ready1), 64'd1);

    // Back-to-back with in_valid held high.
    in_addr1 = 4'h3; in_payload1 = 32'h0000_0001; in_valid1 = 1'b1;
    @(negedge clock);
    in_addr1 = 4'h5; in_payload1 = 32'h8000_0000;
    capture(64'd0);
    make_exp(4'h3, 32'h0000_0001, 32, 5, 64'd0);
    check_pkt("b2b first");
    check("b2b gap ready", 64'(in_ready1), 64'd1);
    check("b2b gap idle", 64'({frame_n1, valid_n1}), 64'(2'b11));
    @(negedge clock);
    in_valid1 = 1'b0;
    capture(64'd0);
    make_exp(4'h5, 32'h8000_0000, 32, 5, 64'd0);
    check_pkt("b2b second");

    // Hold bubbles: 3 before bit 10, 1 before bit 31, plus ignored holds in ADDR/PAD.
    in_addr1 = 4'h2; in_payload1 = 32'hF0F0_5A5A; in_valid1 = 1'b1;
    @(negedge clock);
    in_valid1 = 1'b0;
    capture(64'h0000_0400_001C_0184);
    make_exp(4'h2, 32'hF0F0_5A5A, 32, 5, 64'h0000_0800_0038_0000);
    check_pkt("hold");
    check("hold len hand", 64'(clen), 64'd45);
    check("hold frame_n", cf[44:0], {1'b1, 44'd0});
    check("hold bubbles", 64'({cv[43], cv[21:19]}), 64'hF);
    check("hold payload", 64'({cd[44], cd[42:22], cd[18:9]}), 64'hF0F0_5A5A);

    // Reset during payload bit 12.
    in_addr1 = 4'h9; in_payload1 = 32'h0000_1000; in_valid1 = 1'b1;
    @(negedge clock);
    in_valid1 = 1'b0;
    repeat (21) @(negedge clock);
    check("rst bit12", 64'({valid_n1, di1}), 64'(2'b01));
    rx_before = rx_pkts;
    reset = 1'b1;
    @(negedge clock);
    check("rst outs", 64'({frame_n1, valid_n1, di1, busy1, done1}), 64'(5'b11000));
    check("rst ready", 64'(in_ready1), 64'd0);
    reset = 1'b0;
    #1;
    check("rst ready after", 64'(in_ready1), 64'd1);
    in_addr1 = 4'hC; in_payload1 = 32'hCAFE_F00D; in_valid1 = 1'b1;
    @(negedge clock);
    in_valid1 = 1'b0;
    capture(64'd0);
    make_exp(4'hC, 32'hCAFE_F00D, 32, 5, 64'd0);
    check_pkt("after rst");
    check("rst dropped rx", 64'(rx_pkts - rx_before), 64'd1);

    // Round trip through the receiver.
    rx_before = rx_pkts;
    in_addr1 = 4'h7; in_payload1 = 32'h1234_5678; in_valid1 = 1'b1;
    @(negedge clock);
    in_valid1 = 1'b0;
    capture(64'd0);
    check("rx count", 64'(rx_pkts - rx_before), 64'd1);
    check("rx addr", 64'(rx_last_addr), 64'h7);
    check("rx payload", 64'(rx_last_pay), 64'h1234_5678);

    // Corner instance: PAD=0, WIDTH=8.
    sel = 1'b1;
    in_addr2 = 4'h6; in_payload2 = 8'hA5; in_valid2 = 1'b1;
    @(negedge clock);
    in_valid2 = 1'b0;
    capture(64'd0);
    make_exp(4'h6, 32'h0000_00A5, 8, 0, 64'd0);
    check_pkt("small");
    check("small len hand", 64'(clen), 64'd12);
    check("small done", cdone, 64'h800);
    check("small addr", 64'(cd[3:0]), 64'h6);
    check("small payload", 64'(cd[11:4]), 64'hA5);
    check("small valid_n", 64'(cv[11:0]), 64'h00F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
